// File: rtl/bcd_updown_counter_7seg.sv
// Debounced push-button up/down BCD counter driving active-low 7-segment displays.
// Define AUTO_REPEAT_EN to add hold-to-repeat stepping on a single held key.
module bcd_updown_counter_7seg #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WRAP            = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_up_n,
  input  logic                    key_down_n,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    wrap_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 6 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("bcd_updown_counter_7seg: parameter out of range");
  end

  // Bit 0 carries the up key, bit 1 the down key, throughout the key path.
  logic [1:0]      keys;
  logic [1:0]      sync1, sync2, deb, deb_prev, armed;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      settle;
  logic [1:0]      press;
  logic [1:0]      rep_step;
  logic [1:0]      step;

  assign keys = {key_down_n, key_up_n};

  // A key may only step once it has been seen released after reset; settle
  // waits for the synchroniser to refill with real samples before trusting it.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '1;
      deb_prev <= '1;
      armed    <= '0;
      settle   <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= keys;
      sync2    <= sync1;
      deb_prev <= deb;
      if (settle != 2'd2) settle <= settle + 2'd1;
      for (int i = 0; i < 2; i++) begin
        if (settle == 2'd2 && sync2[i]) armed[i] <= 1'b1;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = deb_prev & ~deb & armed;

`ifdef AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  logic [RP_W-1:0] rep_cnt;
  logic [RP_W-1:0] rep_lim;
  logic            rep_phase;
  logic            one_held;

  assign one_held = (~deb[0] & armed[0] & deb[1]) | (~deb[1] & armed[1] & deb[0]);
  assign rep_lim  = rep_phase ? RP_W'(REPEAT_PERIOD - 1) : RP_W'(REPEAT_DELAY - 1);

  always_ff @(posedge clk) begin
    if (rst || !one_held || (|press)) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_cnt == rep_lim) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + RP_W'(1);
    end
  end

  // With exactly one key held, ~deb has just that key's bit set.
  assign rep_step = (one_held && press == 2'b00 && rep_cnt == rep_lim) ? ~deb : 2'b00;
`else
  assign rep_step = 2'b00;
`endif

  assign step = press | rep_step;

  logic [4*NUM_DIGITS-1:0] bcd_inc, bcd_dec;
  logic                    all9, all0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic carry, borrow;
    bcd_inc = bcd;
    bcd_dec = bcd;
    all9    = 1'b1;
    all0    = 1'b1;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (bcd[4*i +: 4] != 4'd0) all0 = 1'b0;
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) bcd_inc[4*i +: 4] = 4'd0;
        else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd[4*i +: 4] == 4'd0) bcd_dec[4*i +: 4] = 4'd9;
        else begin
          bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd        <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (step[0] && !step[1]) begin
        if (!all9) bcd <= bcd_inc;
        else if (WRAP != 0) begin
          bcd        <= '0;
          wrap_pulse <= 1'b1;
        end
      end else if (step[1] && !step[0]) begin
        if (!all0) bcd <= bcd_dec;
        else if (WRAP != 0) begin
          bcd        <= {NUM_DIGITS{4'd9}};
          wrap_pulse <= 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b100_0000;
      4'd1:    seg7 = 7'b111_1001;
      4'd2:    seg7 = 7'b010_0100;
      4'd3:    seg7 = 7'b011_0000;
      4'd4:    seg7 = 7'b001_1001;
      4'd5:    seg7 = 7'b001_0010;
      4'd6:    seg7 = 7'b000_0010;
      4'd7:    seg7 = 7'b111_1000;
      4'd8:    seg7 = 7'b000_0000;
      4'd9:    seg7 = 7'b001_0000;
      default: seg7 = 7'b111_1111;
    endcase
  endfunction

  always_comb begin
    hex = '1;
    for (int i = 0; i < NUM_DIGITS; i++) hex[7*i +: 7] = seg7(bcd[4*i +: 4]);
  end

endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// Self-checking bench: integer-count reference model compared every cycle,
// directed literal checks, then randomized key/reset stimulus.
module tb_bcd_updown_counter_7seg;

  localparam int ND            = 2;
  localparam int DEB           = 4;
  localparam int WRAP          = 1;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 8;
  localparam int MAXV          = (10 ** ND) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            key_up_n, key_down_n;
  logic [4*ND-1:0] bcd;
  logic [7*ND-1:0] hex;
  logic            wrap_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_updown_counter_7seg #(
    .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB), .WRAP(WRAP),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .key_up_n(key_up_n), .key_down_n(key_down_n),
    .bcd(bcd), .hex(hex), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                               7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                               7'b000_0000, 7'b001_0000};

  int m_count, m_since, m_edge, m_rep_due;
  bit m_pulse, model_valid;
  bit m_s1[2], m_s2[2], m_deb[2], m_armed[2], m_pend[2], m_key[2];
  int m_run[2];
  bit ev_up, ev_dn, one_up, one_dn, old_deb;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7*ND-1:0] to_hex(input int v);
    logic [7*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[7*i +: 7] = seg_tab[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m_key[0] = key_up_n;
    m_key[1] = key_down_n;
    m_edge++;
    if (rst) begin
      model_valid = 1'b1;
      m_count = 0;
      m_pulse = 1'b0;
      m_since = 0;
      m_rep_due = 0;
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_deb[k] = 1'b1;
        m_armed[k] = 1'b0; m_pend[k] = 1'b0; m_run[k] = 0;
      end
    end else begin
      one_up = !m_deb[0] && m_armed[0] && m_deb[1];
      one_dn = !m_deb[1] && m_armed[1] && m_deb[0];
      ev_up  = m_pend[0];
      ev_dn  = m_pend[1];
`ifdef AUTO_REPEAT_EN
      if (!(one_up || one_dn) || m_pend[0] || m_pend[1]) m_rep_due = m_edge + REPEAT_DELAY;
      else if (m_edge == m_rep_due) begin
        if (one_up) ev_up = 1'b1;
        else ev_dn = 1'b1;
        m_rep_due = m_edge + REPEAT_PERIOD;
      end
`endif
      m_pulse = 1'b0;
      if (ev_up && !ev_dn) begin
        if (m_count < MAXV) m_count++;
        else if (WRAP != 0) begin m_count = 0; m_pulse = 1'b1; end
      end else if (ev_dn && !ev_up) begin
        if (m_count > 0) m_count--;
        else if (WRAP != 0) begin m_count = MAXV; m_pulse = 1'b1; end
      end
      for (int k = 0; k < 2; k++) begin
        if (m_since >= 2 && m_s2[k]) m_armed[k] = 1'b1;
        old_deb = m_deb[k];
        if (m_s2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin m_deb[k] = m_s2[k]; m_run[k] = 0; end
        end else m_run[k] = 0;
        m_pend[k] = old_deb && !m_deb[k] && m_armed[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = m_key[k];
      end
      if (m_since < 2) m_since++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_bcd", 32'(bcd), 32'(to_bcd(m_count)));
      check("model_hex", 32'(hex), 32'(to_hex(m_count)));
      check("model_wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit dn);
    key_up_n   = ~up;
    key_down_n = ~dn;
    tick(10);
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    tick(10);
  endtask

  initial begin
    rst = 1'b1; key_up_n = 1'b1; key_down_n = 1'b1;
    tick(2);
    check("reset_bcd", 32'(bcd), 32'h00);
    check("reset_hex", 32'(hex), 32'(14'b1000000_1000000));
    check("reset_wrap_pulse", 32'(wrap_pulse), 32'd0);
    rst = 1'b0;
    tick(5);

    // First press latency: step lands on the 6th edge after the first low sample.
    key_up_n = 1'b0;
    tick(6);
    check("latency_before", 32'(bcd), 32'h00);
    tick(1);
    check("latency_step", 32'(bcd), 32'h01);
    check("hex_one", 32'(hex[6:0]), 32'(7'b111_1001));
    key_up_n = 1'b1;
    tick(12);

    key_down_n = 1'b0;
    tick(3);
    key_down_n = 1'b1;
    tick(12);
    check("glitch_ignored", 32'(bcd), 32'h01);

    repeat (8) press(1, 0);
    check("count_09", 32'(bcd), 32'h09);
    press(1, 0);
    check("carry_10", 32'(bcd), 32'h10);
    repeat (10) press(0, 1);
    check("down_to_00", 32'(bcd), 32'h00);

    key_down_n = 1'b0;
    tick(7);
    check("down_wrap_bcd", 32'(bcd), WRAP ? 32'h99 : 32'h00);
    check("down_wrap_pulse", 32'(wrap_pulse), 32'(WRAP != 0));
    tick(1);
    check("down_wrap_pulse_end", 32'(wrap_pulse), 32'd0);
    key_down_n = 1'b1;
    tick(12);
    if (WRAP == 0) repeat (99) press(1, 0);

    key_up_n = 1'b0;
    tick(7);
    check("up_wrap_bcd", 32'(bcd), WRAP ? 32'h00 : 32'h99);
    check("up_wrap_pulse", 32'(wrap_pulse), 32'(WRAP != 0));
    key_up_n = 1'b1;
    tick(12);

    press(1, 1);
    check("both_no_change", 32'(bcd), WRAP ? 32'h00 : 32'h99);

    // Reset while a press is mid-debounce; the held key must not step afterwards.
    rst = 1'b1; tick(1); rst = 1'b0; tick(2);
    press(1, 0);
    check("pre_reset_count", 32'(bcd), 32'h01);
    key_up_n = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(15);
    check("held_after_reset", 32'(bcd), 32'h00);
    key_up_n = 1'b1;
    tick(10);
    check("released_after_reset", 32'(bcd), 32'h00);
    press(1, 0);
    check("fresh_press", 32'(bcd), 32'h01);

`ifdef AUTO_REPEAT_EN
    rst = 1'b1; tick(1); rst = 1'b0; tick(3);
    key_up_n = 1'b0;
    tick(35);
    check("repeat_three", 32'(bcd), 32'h03);
    key_up_n = 1'b1;
    tick(15);
    check("repeat_hold_03", 32'(bcd), 32'h03);
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
      key_up_n   = 1'($urandom_range(0, 1));
      key_down_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        key_down_n = 1'($urandom_range(0, 1));
        key_up_n   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end
      tick(($urandom_range(0, 7) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 12));
    end
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
